fu_div_arbiter: RTL

FU_DIV_ARBITER -- requirements
Module: fu_div_arbiter

---
 rtl/fu_div_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/fu_div_arbiter.sv
// Round-robin arbiter letting N_REQ requesters share one iterative divider, one division in flight.
// Optional macro DIV_ARB_ZERO_BYPASS_EN answers divide-by-zero locally instead of using the divider.
module fu_div_arbiter #(
    parameter int N_REQ  = 4,
    parameter int N_BITS = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ*N_BITS-1:0] req_a_i,
    input  logic [N_REQ*N_BITS-1:0] req_b_i,
    input  logic [N_REQ-1:0]        req_signed_i,
    output logic [N_REQ-1:0]        req_ready_o,

    output logic [N_REQ-1:0]        rsp_valid_o,
    input  logic [N_REQ-1:0]        rsp_ready_i,
    output logic [N_BITS-1:0]       rsp_q_o,
    output logic [N_BITS-1:0]       rsp_r_o,

    output logic                    div_in_valid_o,
    output logic [N_BITS-1:0]       div_a_o,
    output logic [N_BITS-1:0]       div_b_o,
    output logic                    div_signed_o,
    input  logic                    div_valid_i,
    input  logic [N_BITS-1:0]       div_q_i,
    input  logic [N_BITS-1:0]       div_r_i,

    output logic                    busy_o
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

`ifdef DIV_ARB_ZERO_BYPASS_EN
    localparam bit ZERO_BYPASS = 1'b1;
`else
    localparam bit ZERO_BYPASS = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   owner_q;
    logic [N_BITS-1:0]  a_q, b_q;
    logic               signed_q;
    logic               start_q;
    logic [N_BITS-1:0]  q_q, r_q;

    logic [N_REQ-1:0]   grant;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_found;
    logic [N_BITS-1:0]  gnt_a, gnt_b;
    logic               gnt_signed;
    logic               accept;
    logic               zero_hit;
    logic               div_done;
    logic               rsp_done;

    // Rotating priority search starting at rr_ptr_q.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        grant     = '0;
        gnt_idx   = '0;
        gnt_found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            int               idx;
            logic [IDX_W-1:0] idx_v;
            idx = int'(rr_ptr_q) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            idx_v = idx[IDX_W-1:0];
            if (!gnt_found && req_valid_i[idx_v]) begin
                grant[idx_v] = 1'b1;
                gnt_idx      = idx_v;
                gnt_found    = 1'b1;
            end
        end
    end

    assign gnt_a      = req_a_i[int'(gnt_idx)*N_BITS +: N_BITS];
    assign gnt_b      = req_b_i[int'(gnt_idx)*N_BITS +: N_BITS];
    assign gnt_signed = req_signed_i[gnt_idx];

    // Grants only come from IDLE, and never while reset is held.
    assign accept      = (state_q == IDLE) && !rst_i && gnt_found;
    assign req_ready_o = accept ? grant : '0;
    assign zero_hit    = ZERO_BYPASS && (gnt_b == '0);

    // The start cycle is excluded so a stale result from an abandoned division cannot land.
    assign div_done = (state_q == BUSY) && !start_q && div_valid_i;
    assign rsp_done = (state_q == RESP) && rsp_ready_i[owner_q];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = zero_hit ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (div_done) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the datapath registers are reset as well, since all outputs must read zero after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            start_q  <= 1'b0;
            q_q      <= '0;
            r_q      <= '0;
        end else begin
            state_q <= state_d;
            start_q <= accept && !zero_hit;

            if (accept) begin
                owner_q  <= gnt_idx;
                a_q      <= gnt_a;
                b_q      <= gnt_b;
                signed_q <= gnt_signed;
            end

            // Divide-by-zero bypass follows RISC-V: q = all ones, r = dividend, signed or not.
            if (accept && zero_hit) begin
                q_q <= '1;
                r_q <= gnt_a;
            end else if (div_done) begin
                q_q <= div_q_i;
                r_q <= div_r_i;
            end

            if (rsp_done) begin
                rr_ptr_q <= (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
            end
        end
    end

    always_comb begin
        rsp_valid_o = '0;
        if (state_q == RESP) begin
            rsp_valid_o[owner_q] = 1'b1;
        end
    end

    assign rsp_q_o        = q_q;
    assign rsp_r_o        = r_q;
    assign div_in_valid_o = start_q;
    assign div_a_o        = a_q;
    assign div_b_o        = b_q;
    assign div_signed_o   = signed_q;
    assign busy_o         = (state_q != IDLE);

endmodule
